// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset vector,
// instruction-length helper and the per-cycle action encoding.
package if_stage_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

  // One action per rising edge, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    ACT_REDIR     = 3'd0,  // redirect taken now, imem ready
    ACT_PEND_SET  = 3'd1,  // redirect arrives during a refill, park it
    ACT_PEND_TAKE = 3'd2,  // refill done, apply the parked redirect
    ACT_HOLD      = 3'd3,  // downstream stall, freeze pc and IF/ID
    ACT_BUBBLE    = 3'd4,  // refill in progress, insert a bubble
    ACT_ISSUE     = 3'd5   // normal fetch into IF/ID
  } fetch_act_e;

  // Compressed (16-bit) encodings have anything other than 2'b11 in the low bits.
  function automatic bit is_rvc(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: the imem address/data/stall trio, the redirect request
// from later stages and the IF/ID register seen by decode.
interface if_stage_if;
  import if_stage_pkg::*;

  logic [XLEN-1:0] pc;
  logic [ILEN-1:0] ir;
  logic            stall_imem;
  logic            stall_pipe;
  logic            redir;
  logic [XLEN-1:0] redir_pc;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_ir;
  logic            id_rvc;

  // The fetch stage itself.
  modport master (
    output pc, id_valid, id_pc, id_ir, id_rvc,
    input  ir, stall_imem, stall_pipe, redir, redir_pc
  );

  // Everything around it: imem, hazard unit, redirect source, decode.
  modport slave (
    input  pc, id_valid, id_pc, id_ir, id_rvc,
    output ir, stall_imem, stall_pipe, redir, redir_pc
  );

endinterface

// File: rtl/if_npc.sv
// Next-PC datapath: sizes the current word, forms the sequential PC and
// selects between redirect target, parked redirect and sequential PC.
module if_npc
  import if_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      ir_op,
  input  logic            redir,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            pend_v,
  input  logic [XLEN-1:0] pend_pc,
  output logic            rvc,
  output logic [XLEN-1:0] seq_pc,
  output logic [XLEN-1:0] redir_tgt,
  output logic [XLEN-1:0] next_pc
);

  localparam logic [XLEN-1:0] STEP_RVC = XLEN'(2);
  localparam logic [XLEN-1:0] STEP_STD = XLEN'(4);

  assign rvc       = is_rvc(ir_op);
  // Wraps modulo 2^XLEN on purpose.
  assign seq_pc    = pc + (rvc ? STEP_RVC : STEP_STD);
  // Instructions are at least halfword aligned, so bit 0 is dropped.
  assign redir_tgt = {redir_pc[XLEN-1:1], 1'b0};

  // Pick the PC source; the caller decides whether pc actually loads it.
  always_comb begin
    next_pc = seq_pc;
    if (redir) begin
      next_pc = redir_tgt;
    end else if (pend_v) begin
      next_pc = pend_pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, holds a single parked redirect while
// imem refills, and registers {pc, ir} into IF/ID for decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_PC
) (
  input logic          clk,
  input logic          rst_n,
  if_stage_if.master   bus
);

  logic [XLEN-1:0] pc_q;
  logic            pend_v;
  logic [XLEN-1:0] pend_pc;
  logic            id_valid_q;
  logic [XLEN-1:0] id_pc_q;
  logic [ILEN-1:0] id_ir_q;
  logic            id_rvc_q;

  logic            rvc;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] next_pc;
  fetch_act_e      act;

  if_npc u_npc (
    .pc        (pc_q),
    .ir_op     (bus.ir[1:0]),
    .redir     (bus.redir),
    .redir_pc  (bus.redir_pc),
    .pend_v    (pend_v),
    .pend_pc   (pend_pc),
    .rvc       (rvc),
    .seq_pc    (seq_pc),
    .redir_tgt (redir_tgt),
    .next_pc   (next_pc)
  );

  // Resolve this cycle's action; a redirect always wins so it can squash IF/ID
  // even when decode is stalled, and a parked redirect beats stall_pipe.
  always_comb begin
    act = ACT_ISSUE;
    if (bus.redir && !bus.stall_imem) begin
      act = ACT_REDIR;
    end else if (bus.redir) begin
      act = ACT_PEND_SET;
    end else if (!bus.stall_imem && pend_v) begin
      act = ACT_PEND_TAKE;
    end else if (bus.stall_pipe) begin
      act = ACT_HOLD;
    end else if (bus.stall_imem) begin
      act = ACT_BUBBLE;
    end
  end

  // PC only moves when imem is not refilling, so the refill address stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_ADDR;
    end else if (act == ACT_REDIR || act == ACT_PEND_TAKE || act == ACT_ISSUE) begin
      pc_q <= next_pc;
    end
  end

  // Single-entry parked redirect; a later redirect in the same refill overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v  <= 1'b0;
      pend_pc <= '0;
    end else begin
      case (act)
        ACT_REDIR:     pend_v <= 1'b0;
        ACT_PEND_SET: begin
          pend_v  <= 1'b1;
          pend_pc <= redir_tgt;
        end
        ACT_PEND_TAKE: pend_v <= 1'b0;
        default:       ;
      endcase
    end
  end

  // IF/ID register: load on a clean fetch, hold on downstream stall, else bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_ir_q    <= '0;
      id_rvc_q   <= 1'b0;
    end else begin
      case (act)
        ACT_HOLD: ;
        ACT_ISSUE: begin
          id_valid_q <= 1'b1;
          id_pc_q    <= pc_q;
          id_ir_q    <= rvc ? {16'b0, bus.ir[15:0]} : bus.ir;
          id_rvc_q   <= rvc;
        end
        default:   id_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.id_valid = id_valid_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_ir    = id_ir_q;
  assign bus.id_rvc   = id_rvc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a vector table walked one clock per entry,
// followed by an asynchronous reset taken in the middle of a refill.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] ir;
    logic        si;
    logic        sp;
    logic        rd;
    logic [63:0] rpc;
    logic [63:0] e_pc;
    logic        e_v;
    logic [63:0] e_idpc;
    logic [31:0] e_ir;
    logic        e_rvc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] ir, input logic si, input logic sp, input logic rd,
                     input logic [63:0] rpc, input logic [63:0] e_pc, input logic e_v,
                     input logic [63:0] e_idpc, input logic [31:0] e_ir, input logic e_rvc);
    vec_t v;
    v.ir = ir; v.si = si; v.sp = sp; v.rd = rd; v.rpc = rpc;
    v.e_pc = e_pc; v.e_v = e_v; v.e_idpc = e_idpc; v.e_ir = e_ir; v.e_rvc = e_rvc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic si, input logic sp, input logic rd,
                       input logic [63:0] rpc);
    bus.ir = ir; bus.stall_imem = si; bus.stall_pipe = sp; bus.redir = rd; bus.redir_pc = rpc;
  endtask

  task automatic check_all(input string tag, input logic [63:0] e_pc, input logic e_v,
                           input logic [63:0] e_idpc, input logic [31:0] e_ir, input logic e_rvc);
    check({tag, ".pc"},       bus.pc,              e_pc);
    check({tag, ".id_valid"}, 64'(bus.id_valid),   64'(e_v));
    check({tag, ".id_pc"},    bus.id_pc,           e_idpc);
    check({tag, ".id_ir"},    64'(bus.id_ir),      64'(e_ir));
    check({tag, ".id_rvc"},   64'(bus.id_rvc),     64'(e_rvc));
  endtask

  localparam logic [63:0] P = 64'h8000_0000;
  localparam logic [63:0] TOP4 = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] TOP2 = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(NOP, 1'b0, 1'b0, 1'b0, 64'h0);

    //      ir            si sp rd rpc          e_pc        v  e_idpc     e_ir          rvc
    add(NOP,           0, 0, 0, 0,          P+4,        1, P,         NOP,          0);  // T1 first fetch
    add(NOP,           0, 0, 1, P,          P,          0, P,         NOP,          0);  // back to base
    add(32'hFFFF_4501, 0, 0, 0, 0,          P+2,        1, P,         32'h4501,     1);  // T2 RVC, top zeroed
    add(NOP,           0, 0, 0, 0,          P+6,        1, P+2,       NOP,          0);
    add(32'h0000_0002, 0, 0, 0, 0,          P+8,        1, P+6,       32'h2,        1);
    add(NOP,           0, 0, 1, P+'h11,     P+'h10,     0, P+6,       32'h2,        1);  // bit0 dropped
    for (int i = 0; i < 5; i++)                                                        // T3 miss
      add(32'hDEAD_BEEF, 1, 0, 0, 0,        P+'h10,     0, P+6,       32'h2,        1);
    add(32'h0010_0093, 0, 0, 0, 0,          P+'h14,     1, P+'h10,    32'h0010_0093, 0);
    add(NOP,           1, 0, 1, P+'h101,    P+'h14,     0, P+'h10,    32'h0010_0093, 0); // T4 redirect in miss
    add(NOP,           1, 0, 0, 0,          P+'h14,     0, P+'h10,    32'h0010_0093, 0);
    add(NOP,           0, 0, 0, 0,          P+'h100,    0, P+'h10,    32'h0010_0093, 0); // parked target, dropped ir
    add(NOP,           0, 0, 0, 0,          P+'h104,    1, P+'h100,   NOP,          0);
    add(NOP,           0, 0, 1, P+'h20,     P+'h20,     0, P+'h100,   NOP,          0);
    add(NOP,           0, 0, 0, 0,          P+'h24,     1, P+'h20,    NOP,          0);
    for (int i = 0; i < 3; i++)                                                        // T5 stall_pipe
      add(32'h4501,    0, 1, 0, 0,          P+'h24,     1, P+'h20,    NOP,          0);
    add(32'h4501,      1, 1, 0, 0,          P+'h24,     1, P+'h20,    NOP,          0);  // pipe beats imem
    add(NOP,           0, 1, 1, P+'h200,    P+'h200,    0, P+'h20,    NOP,          0);  // redirect kills IF/ID
    add(NOP,           1, 0, 1, P+'h300,    P+'h200,    0, P+'h20,    NOP,          0);
    add(NOP,           1, 0, 1, P+'h401,    P+'h200,    0, P+'h20,    NOP,          0);  // overwrite parked
    add(NOP,           0, 1, 0, 0,          P+'h400,    0, P+'h20,    NOP,          0);  // parked beats stall_pipe
    add(32'h4501,      0, 0, 0, 0,          P+'h402,    1, P+'h400,   32'h4501,     1);
    add(NOP,           0, 0, 1, TOP4,       TOP4,       0, P+'h400,   32'h4501,     1);  // T6 wrap
    add(NOP,           0, 0, 0, 0,          64'h0,      1, TOP4,      NOP,          0);
    add(NOP,           0, 0, 1, TOP2,       TOP2,       0, TOP4,      NOP,          0);
    add(32'h4501,      0, 0, 0, 0,          64'h0,      1, TOP2,      32'h4501,     1);
    add(NOP,           1, 0, 1, P+'h500,    64'h0,      0, TOP2,      32'h4501,     1);
    add(NOP,           0, 0, 1, P+'h600,    P+'h600,    0, TOP2,      32'h4501,     1);  // new redirect clears parked
    add(NOP,           0, 0, 0, 0,          P+'h604,    1, P+'h600,   NOP,          0);

    // Reset held for four cycles.
    repeat (4) @(posedge clk);
    #1;
    check_all("reset", P, 1'b0, 64'h0, 32'h0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ir, vecs[i].si, vecs[i].sp, vecs[i].rd, vecs[i].rpc);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_v,
                vecs[i].e_idpc, vecs[i].e_ir, vecs[i].e_rvc);
    end

    // Async reset in the middle of a refill with a redirect parked.
    drive(NOP, 1'b1, 1'b0, 1'b1, P+'h700);
    @(posedge clk);
    #1;
    check("midrst.park_pc", bus.pc, P+'h604);
    drive(NOP, 1'b1, 1'b0, 1'b0, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.pc_async", bus.pc, P);
    check("midrst.valid_async", 64'(bus.id_valid), 64'h0);
    check("midrst.id_pc_async", bus.id_pc, 64'h0);
    #1;
    rst_n = 1'b1;
    drive(NOP, 1'b0, 1'b0, 1'b0, 64'h0);
    @(posedge clk);
    #1;
    check_all("postrst", P+4, 1'b1, P, NOP, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
